bti_sram_arb: RTL and testbench

BTI_SRAM_ARB -- requirements
Module: bti_sram_arb

---
 rtl/bti_sram_arb_pkg.sv | 28 ++
 rtl/bti_sram_arb_if.sv | 30 +++
 rtl/bti_arb_ord_fifo.sv | 65 ++++++
 rtl/bti_sram_arb.sv | 123 ++++++++++++
 tb/tb_bti_sram_arb.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bti_sram_arb_pkg.sv
// Shared BTI definitions: command encodings, transaction-ID width, requester IDs
// and the arbiter hold-state encoding used by bti_sram_arb and its order FIFO.
package bti_sram_arb_pkg;

  localparam int BTI_TIDW = 4;

  typedef enum logic [1:0] {
    BTI_CMD_RD = 2'd0,
    BTI_CMD_WR = 2'd1
  } bti_cmd_e;

  typedef logic bti_rid_t;

  localparam bti_rid_t RID_M0 = 1'b0;
  localparam bti_rid_t RID_M1 = 1'b1;

  // A hold state pins the grant to one requester while its request is stalled.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_HOLD_M0 = 2'd1,
    ARB_HOLD_M1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e hold_state(input bti_rid_t rid);
    return (rid == RID_M1) ? ARB_HOLD_M1 : ARB_HOLD_M0;
  endfunction

endpackage

// File: rtl/bti_sram_arb_if.sv
// BTI request and response channel interfaces (valid/ready handshake with a
// payload), each with a master-side and slave-side modport.
interface bti_req_if_t import bti_sram_arb_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic                vld;
  logic                rdy;
  logic [AW-1:0]       addr;
  bti_cmd_e            cmd;
  logic [DW/8-1:0]     strobe;
  logic [DW-1:0]       data;
  logic [BTI_TIDW-1:0] tid;

  modport mst (output vld, addr, cmd, strobe, data, tid, input rdy);
  modport slv (input vld, addr, cmd, strobe, data, tid, output rdy);
endinterface

interface bti_rsp_if_t import bti_sram_arb_pkg::*; #(
  parameter int DW = 32
);
  logic                vld;
  logic                rdy;
  logic [DW-1:0]       data;
  logic                err;
  logic [BTI_TIDW-1:0] tid;

  modport mst (output vld, data, err, tid, input rdy);
  modport slv (input vld, data, err, tid, output rdy);
endinterface

// File: rtl/bti_arb_ord_fifo.sv
// Order FIFO holding the requester ID of every granted request until its
// in-order response returns; pointers carry an extra MSB to tell full from empty.
module bti_arb_ord_fifo import bti_sram_arb_pkg::*; #(
  parameter int OSD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  bti_rid_t             push_id_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 empty_o,
  output bti_rid_t             head_o,
  output logic [$clog2(OSD):0] cnt_o
);

  localparam int PW = $clog2(OSD);
  localparam logic [PW:0] ONE = 1;

  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;
  logic [PW:0] cnt_q, cnt_d;
  bti_rid_t    mem_q [OSD];
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[PW-1:0]];
  assign cnt_o   = cnt_q;

  // A push into a full FIFO is refused even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = do_push ? wptr_q + ONE : wptr_q;
    rptr_d = do_pop  ? rptr_q + ONE : rptr_q;
    cnt_d  = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + ONE;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[PW-1:0]] <= push_id_i;
    end
  end

endmodule

// File: rtl/bti_sram_arb.sv
// Two-requester arbiter in front of a shared bti_sram with in-order response routing.
// Define BTI_SRAM_ARB_RR_EN for round-robin; otherwise m1 (LSU) has fixed priority.
module bti_sram_arb import bti_sram_arb_pkg::*; #(
  parameter int BTI_AW = 32,
  parameter int BTI_DW = 32,
  parameter int OSD    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bti_req_if_t.slv             m0_req_slv,
  bti_rsp_if_t.mst             m0_rsp_mst,
  bti_req_if_t.slv             m1_req_slv,
  bti_rsp_if_t.mst             m1_rsp_mst,
  bti_req_if_t.mst             s_req_mst,
  bti_rsp_if_t.slv             s_rsp_slv,
  output logic [$clog2(OSD):0] osd_cnt
);

  arb_state_e            state_q, state_d;
  bti_rid_t              contend_id;
  bti_rid_t              gnt_id;
  logic                  gnt_vld;
  logic                  s_vld;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  bti_rid_t              head_id;
  logic [BTI_AW-1:0]     addr_mux;
  logic [BTI_DW-1:0]     wdata_mux;
  logic [BTI_DW/8-1:0]   strobe_mux;
  logic [BTI_DW-1:0]     rsp_data;

`ifdef BTI_SRAM_ARB_RR_EN
  bti_rid_t prio_q, prio_d;

  assign contend_id = prio_q;
  assign prio_d     = push ? ~gnt_id : prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= RID_M0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign contend_id = RID_M1;
`endif

  // A stalled grant stays with its requester until the handshake completes.
  always_comb begin
    gnt_id  = RID_M0;
    state_d = ARB_IDLE;
    if (state_q == ARB_HOLD_M0 && m0_req_slv.vld) begin
      gnt_id = RID_M0;
    end else if (state_q == ARB_HOLD_M1 && m1_req_slv.vld) begin
      gnt_id = RID_M1;
    end else if (m0_req_slv.vld && m1_req_slv.vld) begin
      gnt_id = contend_id;
    end else if (m1_req_slv.vld) begin
      gnt_id = RID_M1;
    end
    gnt_vld = (gnt_id == RID_M1) ? m1_req_slv.vld : m0_req_slv.vld;
    s_vld   = gnt_vld && !fifo_full;
    push    = s_vld && s_req_mst.rdy;
    if (gnt_vld && !push) begin
      state_d = hold_state(gnt_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign addr_mux   = (gnt_id == RID_M1) ? m1_req_slv.addr   : m0_req_slv.addr;
  assign wdata_mux  = (gnt_id == RID_M1) ? m1_req_slv.data   : m0_req_slv.data;
  assign strobe_mux = (gnt_id == RID_M1) ? m1_req_slv.strobe : m0_req_slv.strobe;

  assign s_req_mst.vld    = s_vld;
  assign s_req_mst.addr   = addr_mux;
  assign s_req_mst.cmd    = (gnt_id == RID_M1) ? m1_req_slv.cmd : m0_req_slv.cmd;
  assign s_req_mst.strobe = strobe_mux;
  assign s_req_mst.data   = wdata_mux;
  assign s_req_mst.tid    = (gnt_id == RID_M1) ? m1_req_slv.tid : m0_req_slv.tid;

  assign m0_req_slv.rdy = push && (gnt_id == RID_M0);
  assign m1_req_slv.rdy = push && (gnt_id == RID_M1);

  // Responses return in grant order, so the FIFO head names their owner.
  assign s_rsp_slv.rdy  = !fifo_empty && ((head_id == RID_M1) ? m1_rsp_mst.rdy : m0_rsp_mst.rdy);
  assign pop            = s_rsp_slv.vld && s_rsp_slv.rdy;
  assign rsp_data       = s_rsp_slv.data;

  assign m0_rsp_mst.vld  = s_rsp_slv.vld && !fifo_empty && (head_id == RID_M0);
  assign m0_rsp_mst.data = rsp_data;
  assign m0_rsp_mst.err  = s_rsp_slv.err;
  assign m0_rsp_mst.tid  = s_rsp_slv.tid;

  assign m1_rsp_mst.vld  = s_rsp_slv.vld && !fifo_empty && (head_id == RID_M1);
  assign m1_rsp_mst.data = rsp_data;
  assign m1_rsp_mst.err  = s_rsp_slv.err;
  assign m1_rsp_mst.tid  = s_rsp_slv.tid;

  bti_arb_ord_fifo #(
    .OSD (OSD)
  ) u_ord_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_id_i (gnt_id),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head_id),
    .cnt_o     (osd_cnt)
  );

endmodule

// File: tb/tb_bti_sram_arb.sv
// Self-checking bench for bti_sram_arb: directed scenarios plus random traffic,
// checked against a queue-based model of grant order and response routing.
module tb_bti_sram_arb;
  import bti_sram_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int OSD = 4;
  localparam int CW  = $clog2(OSD) + 1;
`ifdef BTI_SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] osd_cnt;

  always #5 clk = ~clk;

  bti_req_if_t #(.AW(AW), .DW(DW)) m0_req ();
  bti_req_if_t #(.AW(AW), .DW(DW)) m1_req ();
  bti_req_if_t #(.AW(AW), .DW(DW)) s_req ();
  bti_rsp_if_t #(.DW(DW))          m0_rsp ();
  bti_rsp_if_t #(.DW(DW))          m1_rsp ();
  bti_rsp_if_t #(.DW(DW))          s_rsp ();

  bti_sram_arb #(
    .BTI_AW (AW),
    .BTI_DW (DW),
    .OSD    (OSD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req_slv (m0_req),
    .m0_rsp_mst (m0_rsp),
    .m1_req_slv (m1_req),
    .m1_rsp_mst (m1_rsp),
    .s_req_mst  (s_req),
    .s_rsp_slv  (s_rsp),
    .osd_cnt    (osd_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model: queue of owners of outstanding requests, pending stalled grant, RR turn.
  bit ord_q[$];
  int lock_m;
  bit prio_m;
  bit e_gnt, e_gvld, e_push, e_pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    ord_q.delete();
    lock_m = -1;
    prio_m = 1'b0;
  endtask

  task automatic randPkt(input bit id);
    if (id) begin
      m1_req.addr   = $urandom;
      m1_req.cmd    = bti_cmd_e'($urandom_range(0, 1));
      m1_req.strobe = 4'($urandom);
      m1_req.data   = $urandom;
      m1_req.tid    = 4'($urandom);
    end else begin
      m0_req.addr   = $urandom;
      m0_req.cmd    = bti_cmd_e'($urandom_range(0, 1));
      m0_req.strobe = 4'($urandom);
      m0_req.data   = $urandom;
      m0_req.tid    = 4'($urandom);
    end
  endtask

  task automatic clearInputs();
    m0_req.vld = 1'b0; m1_req.vld = 1'b0; s_req.rdy = 1'b0;
    s_rsp.vld = 1'b0; s_rsp.data = '0; s_rsp.err = 1'b0; s_rsp.tid = '0;
    m0_rsp.rdy = 1'b0; m1_rsp.rdy = 1'b0;
  endtask

  // Compare every DUT output with the model at the falling edge.
  task automatic checkOutput();
    bit full_m, empty_m, head, rsp_rdy_e;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    full_m  = (ord_q.size() == OSD);
    empty_m = (ord_q.size() == 0);
    head    = empty_m ? 1'b0 : ord_q[0];
    if (lock_m == 0 && m0_req.vld)               e_gnt = 1'b0;
    else if (lock_m == 1 && m1_req.vld)          e_gnt = 1'b1;
    else if (m0_req.vld && m1_req.vld)           e_gnt = RR ? prio_m : 1'b1;
    else                                         e_gnt = m1_req.vld;
    e_gvld    = e_gnt ? m1_req.vld : m0_req.vld;
    e_push    = e_gvld && !full_m && s_req.rdy;
    rsp_rdy_e = !empty_m && (head ? m1_rsp.rdy : m0_rsp.rdy);
    e_pop     = s_rsp.vld && rsp_rdy_e;
    exp_addr  = e_gnt ? m1_req.addr : m0_req.addr;
    chk("s_req.vld", s_req.vld, e_gvld && !full_m);
    chk("m0_req.rdy", m0_req.rdy, e_push && !e_gnt);
    chk("m1_req.rdy", m1_req.rdy, e_push && e_gnt);
    if (e_gvld && !full_m) begin
      chk("s_req.addr", s_req.addr, exp_addr);
      chk("s_req.data", s_req.data, e_gnt ? m1_req.data : m0_req.data);
      chk("s_req.tid", s_req.tid, e_gnt ? m1_req.tid : m0_req.tid);
      chk("s_req.cmd", s_req.cmd, e_gnt ? m1_req.cmd : m0_req.cmd);
    end
    chk("m0_rsp.vld", m0_rsp.vld, s_rsp.vld && !empty_m && !head);
    chk("m1_rsp.vld", m1_rsp.vld, s_rsp.vld && !empty_m && head);
    chk("s_rsp.rdy", s_rsp.rdy, rsp_rdy_e);
    if (s_rsp.vld) begin
      chk("m0_rsp.data", m0_rsp.data, s_rsp.data);
      chk("m1_rsp.data", m1_rsp.data, s_rsp.data);
    end
    chk("osd_cnt", osd_cnt, ord_q.size());
  endtask

  // Advance one clock: update the model and give handshaken masters a new packet.
  task automatic applyStimulus();
    checkOutput();
    @(posedge clk);
    if (!rst_n) begin
      clearModel();
    end else begin
      if (e_pop) void'(ord_q.pop_front());
      if (e_push) begin
        ord_q.push_back(e_gnt);
        prio_m = !e_gnt;
      end
      lock_m = (e_gvld && !e_push) ? int'(e_gnt) : -1;
    end
    #1;
    if (e_push && rst_n) randPkt(e_gnt);
  endtask

  initial begin
    bit m0_hold, m1_hold, rsp_hold;
    rst_n = 1'b0;
    clearInputs();
    randPkt(1'b0);
    randPkt(1'b1);
    clearModel();
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;

    // Single m0 read, response one cycle later.
    m0_req.vld = 1'b1; m0_req.addr = 32'h100; m0_req.cmd = BTI_CMD_RD;
    s_req.rdy = 1'b1; m0_rsp.rdy = 1'b1; m1_rsp.rdy = 1'b1;
    applyStimulus();
    m0_req.vld = 1'b0;
    s_rsp.vld = 1'b1; s_rsp.data = 32'hCAFE_0100;
    applyStimulus();
    chk("single_osd_after_pop", osd_cnt, 0);
    s_rsp.vld = 1'b0;
    applyStimulus();

    // Contention: both requesters valid every cycle.
    m0_req.vld = 1'b1; m1_req.vld = 1'b1;
    for (int i = 0; i < OSD; i++) applyStimulus();
    m0_req.vld = 1'b0; m1_req.vld = 1'b0;
    s_rsp.vld = 1'b1;
    for (int i = 0; i < OSD; i++) begin
      s_rsp.data = $urandom;
      applyStimulus();
    end
    s_rsp.vld = 1'b0;
    applyStimulus();

    // Fill with responses stalled, then pop while a request waits.
    m0_req.vld = 1'b1;
    for (int i = 0; i < OSD + 1; i++) applyStimulus();
    chk("full_osd_cnt", osd_cnt, OSD);
    chk("full_m0_blocked", m0_req.rdy, 1'b0);
    s_rsp.vld = 1'b1;
    applyStimulus();
    chk("pop_while_full_osd", osd_cnt, OSD - 1);
    s_rsp.vld = 1'b0;
    applyStimulus();
    chk("refill_osd", osd_cnt, OSD);
    m0_req.vld = 1'b0;
    s_rsp.vld = 1'b1;
    for (int i = 0; i < OSD; i++) applyStimulus();
    s_rsp.vld = 1'b0;

    // Ordering: m1's response must wait behind a stalled m0 response.
    m0_req.vld = 1'b1; m0_req.cmd = BTI_CMD_RD;
    applyStimulus();
    m0_req.vld = 1'b0;
    m1_req.vld = 1'b1; m1_req.addr = 32'h200; m1_req.cmd = BTI_CMD_WR;
    applyStimulus();
    m1_req.vld = 1'b0;
    s_rsp.vld = 1'b1; s_rsp.data = 32'hAAAA_0000; m0_rsp.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      chk("order_s_rsp_rdy", s_rsp.rdy, 1'b0);
      chk("order_m1_rsp_vld", m1_rsp.vld, 1'b0);
    end
    m0_rsp.rdy = 1'b1;
    applyStimulus();
    s_rsp.data = 32'hBBBB_0000;
    applyStimulus();
    s_rsp.vld = 1'b0;
    applyStimulus();

    // Random traffic with protocol-respecting masters and memory.
    m0_hold = 1'b0; m1_hold = 1'b0; rsp_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!m0_hold) begin
        m0_req.vld = ($urandom_range(0, 2) != 0);
        randPkt(1'b0);
      end
      if (!m1_hold) begin
        m1_req.vld = ($urandom_range(0, 2) != 0);
        randPkt(1'b1);
      end
      if (!rsp_hold) begin
        s_rsp.vld  = (ord_q.size() > 0) && ($urandom_range(0, 1) != 0);
        s_rsp.data = $urandom;
        s_rsp.tid  = 4'($urandom);
      end
      s_req.rdy  = ($urandom_range(0, 3) != 0);
      m0_rsp.rdy = ($urandom_range(0, 2) != 0);
      m1_rsp.rdy = ($urandom_range(0, 2) != 0);
      applyStimulus();
      m0_hold  = m0_req.vld && !(e_push && !e_gnt);
      m1_hold  = m1_req.vld && !(e_push && e_gnt);
      rsp_hold = s_rsp.vld && !e_pop;
    end

    // Drain, then reset with two requests outstanding.
    clearInputs();
    m0_rsp.rdy = 1'b1; m1_rsp.rdy = 1'b1; s_rsp.vld = 1'b1;
    for (int i = 0; i < OSD + 1; i++) applyStimulus();
    clearInputs();
    s_req.rdy = 1'b1; m0_req.vld = 1'b1;
    applyStimulus();
    applyStimulus();
    m0_req.vld = 1'b0;
    applyStimulus();
    chk("pre_reset_osd", osd_cnt, 2);
    rst_n = 1'b0;
    clearModel();
    #1;
    chk("async_reset_osd", osd_cnt, 0);
    applyStimulus();
    rst_n = 1'b1;
    s_rsp.vld = 1'b1; s_rsp.data = 32'hDEAD_BEEF; m0_rsp.rdy = 1'b1; m1_rsp.rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      chk("stray_m0_rsp_vld", m0_rsp.vld, 1'b0);
      chk("stray_s_rsp_rdy", s_rsp.rdy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
